// File: rtl/mbisr_register_array.sv
// mbisr_register_array: one segment of the memory-repair register chain.
// Holds WORDS repair words of WIDTH bits in a single serial shift register,
// tracks how many bits have been shifted since the last capture or update,
// and copies the shift register into the shadow Q only when the load was
// complete. Protocol violations set a sticky ERR.
//
// Optional feature: define MBISR_REGISTER_ARRAY_PARITY_EN to add one even
// parity bit above each word in the shift register. A word whose parity is
// wrong blocks the update.
module mbisr_register_array #(
  parameter int WIDTH = 22,
  parameter int WORDS = 4
) (
  input  logic                     CLK,
  input  logic                     RSTB,
  input  logic                     SI,
  output logic                     SO,
  input  logic                     SE,
  input  logic                     CE,
  input  logic                     UPDATE,
  input  logic                     CLR_ERR,
  input  logic [WORDS*WIDTH-1:0]   D,
  input  logic                     MSO,
  input  logic                     MSEL,
  output logic [WORDS*WIDTH-1:0]   Q,
  output logic                     FULL,
  output logic                     ERR
);

`ifdef MBISR_REGISTER_ARRAY_PARITY_EN
  localparam int WW = WIDTH + 1;
`else
  localparam int WW = WIDTH;
`endif
  localparam int DW  = WORDS * WIDTH;
  localparam int LEN = WORDS * WW;
  localparam int CW  = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PART  = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  logic [LEN-1:0]   sr, sr_n, cap_vec;
  logic [DW-1:0]    sr_data;
  logic [WORDS-1:0] par_bad;
  logic [CW-1:0]    cnt, cnt_n, cnt_inc;
  logic [1:0]       st, st_n;
  logic             q_load, err_set;

  // Per-word mapping between the data view (D/Q) and the chain layout.
  for (genvar k = 0; k < WORDS; k++) begin : g_word
    assign sr_data[k*WIDTH +: WIDTH] = sr[k*WW +: WIDTH];
`ifdef MBISR_REGISTER_ARRAY_PARITY_EN
    assign cap_vec[k*WW +: WW] = {^D[k*WIDTH +: WIDTH], D[k*WIDTH +: WIDTH]};
    assign par_bad[k]          = ^sr[k*WW +: WW];
`else
    assign cap_vec[k*WW +: WW] = D[k*WIDTH +: WIDTH];
    assign par_bad[k]          = 1'b0;
`endif
  end

  assign cnt_inc = (cnt == LEN_C) ? cnt : cnt + 1'b1;
  assign FULL    = (st == S_FULL);

  // Next-state for chain, counter and FSM; SE beats CE beats UPDATE.
  always_comb begin
    sr_n    = sr;
    cnt_n   = cnt;
    st_n    = st;
    q_load  = 1'b0;
    err_set = 1'b0;
    if (SE) begin
      sr_n  = {SI, sr[LEN-1:1]};
      // A resumed partial load counts afresh: this edge is bit 1.
      cnt_n = (st == S_PART) ? CW'(1) : cnt_inc;
      if (st == S_FULL || cnt_n == LEN_C) st_n = S_FULL;
      else                                 st_n = S_SHIFT;
    end else if (CE) begin
      sr_n  = cap_vec;
      cnt_n = '0;
      st_n  = S_IDLE;
    end else begin
      // Shifting stopped short of a full load.
      if (st == S_SHIFT) st_n = S_PART;
      if (UPDATE) begin
        if (st == S_IDLE || st == S_FULL) begin
          cnt_n = '0;
          st_n  = S_IDLE;
          if (|par_bad) err_set = 1'b1;
          else          q_load  = 1'b1;
        end else begin
          // Incomplete chain content must never reach the memories.
          err_set = 1'b1;
        end
      end
    end
  end

  // Chain, counter, FSM and shadow register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sr  <= '0;
      cnt <= '0;
      st  <= S_IDLE;
      Q   <= '0;
    end else begin
      sr  <= sr_n;
      cnt <= cnt_n;
      st  <= st_n;
      if (q_load) Q <= sr_data;
    end
  end

  // Sticky error; a new error in the same cycle as CLR_ERR wins.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)        ERR <= 1'b0;
    else if (err_set) ERR <= 1'b1;
    else if (CLR_ERR) ERR <= 1'b0;
  end

  // Falling-edge retime of serial out gives downstream half a cycle of hold.
  always_ff @(negedge CLK or negedge RSTB) begin
    if (!RSTB) SO <= 1'b0;
    else       SO <= MSEL ? MSO : sr[0];
  end

endmodule

// File: tb/tb_mbisr_register_array.sv
// Directed bench for mbisr_register_array (WIDTH=22, WORDS=4): a vector table
// for control sequencing, plus hand sequences for full load, unload, bypass,
// parity (when MBISR_REGISTER_ARRAY_PARITY_EN is defined) and async reset.
module tb_mbisr_register_array;
  localparam int WIDTH = 22;
  localparam int WORDS = 4;
  localparam int DW    = WIDTH * WORDS;
`ifdef MBISR_REGISTER_ARRAY_PARITY_EN
  localparam int WW = WIDTH + 1;
`else
  localparam int WW = WIDTH;
`endif
  localparam int LEN = WW * WORDS;

  localparam logic [DW-1:0] Z  = '0;
  localparam logic [DW-1:0] DA = 88'h12_3456_789A_BCDE_F011_2233;
  localparam logic [DW-1:0] PA = {11{8'hA5}};

  logic CLK = 1'b0, RSTB = 1'b0, SI = 1'b0, SE = 1'b0, CE = 1'b0;
  logic UPDATE = 1'b0, CLR_ERR = 1'b0, MSO = 1'b0, MSEL = 1'b0;
  logic [DW-1:0] D = '0;
  logic SO, FULL, ERR;
  logic [DW-1:0] Q;

  int checks = 0;
  int errors = 0;

  mbisr_register_array #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .CLK(CLK), .RSTB(RSTB), .SI(SI), .SO(SO), .SE(SE), .CE(CE),
    .UPDATE(UPDATE), .CLR_ERR(CLR_ERR), .D(D), .MSO(MSO), .MSEL(MSEL),
    .Q(Q), .FULL(FULL), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          se, ce, upd, clr, si;
    logic [DW-1:0] d;
    logic          exp_full, exp_err;
    logic [DW-1:0] exp_q;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic shift1(input logic b);
    SE = 1'b1; SI = b;
    tick();
    SE = 1'b0; SI = 1'b0;
  endtask

  task automatic capture(input logic [DW-1:0] v);
    D = v; CE = 1'b1;
    tick();
    CE = 1'b0;
  endtask

  task automatic pulse_update();
    UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
  endtask

  // Chain image of a data vector: bit 0 of the result is shifted in first.
  function automatic logic [LEN-1:0] mk_stream(input logic [DW-1:0] d);
    logic [LEN-1:0] s;
    s = '0;
    for (int k = 0; k < WORDS; k++) begin
`ifdef MBISR_REGISTER_ARRAY_PARITY_EN
      s[k*WW +: WW] = {^d[k*WIDTH +: WIDTH], d[k*WIDTH +: WIDTH]};
`else
      s[k*WW +: WW] = d[k*WIDTH +: WIDTH];
`endif
    end
    return s;
  endfunction

  logic [LEN-1:0] stream, got;

  initial begin
    //           se    ce    upd   clr   si    d   full  err   q
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, Z,  1'b0, 1'b0, Z };
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z };
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z };  // partial
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b1, Z };  // bad update
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b1, Z };  // sticky
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Z,  1'b0, 1'b0, Z };  // clear
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, Z,  1'b0, 1'b1, Z };  // set wins
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Z,  1'b0, 1'b0, Z };
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DA, 1'b0, 1'b0, Z };  // CE beats UPDATE
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, DA};  // accepted
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, DA};  // SE beats CE
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, DA};  // partial again
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b1, DA};  // so update rejected
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Z,  1'b0, 1'b0, DA};

    // Reset values.
    #11;
    chk("rst_q", 128'(Q), 128'(0));
    chk("rst_so", 128'(SO), 128'(0));
    chk("rst_full", 128'(FULL), 128'(0));
    chk("rst_err", 128'(ERR), 128'(0));
    #1 RSTB = 1'b1;

    // Control sequencing table.
    for (int i = 0; i < 14; i++) begin
      SE = tbl[i].se; CE = tbl[i].ce; UPDATE = tbl[i].upd;
      CLR_ERR = tbl[i].clr; SI = tbl[i].si; D = tbl[i].d;
      tick();
      chk($sformatf("step%0d_full", i), 128'(FULL), 128'(tbl[i].exp_full));
      chk($sformatf("step%0d_err", i), 128'(ERR), 128'(tbl[i].exp_err));
      chk($sformatf("step%0d_q", i), 128'(Q), 128'(tbl[i].exp_q));
    end
    SE = 1'b0; CE = 1'b0; UPDATE = 1'b0; CLR_ERR = 1'b0; SI = 1'b0;

    // Full load of the A5 pattern.
    capture(Z);
    stream = mk_stream(PA);
    for (int i = 0; i < LEN - 1; i++) shift1(stream[i]);
    chk("load_full_early", 128'(FULL), 128'(0));
    shift1(stream[LEN-1]);
    chk("load_full", 128'(FULL), 128'(1));
    chk("load_q_held", 128'(Q), 128'(DA));
    pulse_update();
    chk("load_q", 128'(Q), 128'(PA));
    chk("load_err", 128'(ERR), 128'(0));
    chk("load_full_cleared", 128'(FULL), 128'(0));

    // Capture and unload, LSB first on the falling edge.
    capture(DA);
    SE = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      @(negedge CLK);
      #1 got[i] = SO;
    end
    SE = 1'b0;
    tick();
    chk("unload_so", 128'(got), 128'(mk_stream(DA)));

    // Bypass: SO follows MSO half a cycle later.
    @(negedge CLK);
    #1 MSEL = 1'b1; MSO = 1'b1;
    @(posedge CLK);
    #1 chk("bypass_hold", 128'(SO), 128'(0));
    @(negedge CLK);
    #1 chk("bypass_hi", 128'(SO), 128'(1));
    MSO = 1'b0;
    @(posedge CLK);
    #1 chk("bypass_hold_hi", 128'(SO), 128'(1));
    @(negedge CLK);
    #1 chk("bypass_lo", 128'(SO), 128'(0));
    MSEL = 1'b0;
    tick();

`ifdef MBISR_REGISTER_ARRAY_PARITY_EN
    // Corrupt word 2's parity: update blocked, error raised.
    capture(Z);
    stream = mk_stream(DA);
    stream[2*WW + WIDTH] = ~stream[2*WW + WIDTH];
    for (int i = 0; i < LEN; i++) shift1(stream[i]);
    chk("par_full", 128'(FULL), 128'(1));
    pulse_update();
    chk("par_q", 128'(Q), 128'(PA));
    chk("par_err", 128'(ERR), 128'(1));
    chk("par_idle", 128'(FULL), 128'(0));
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
`endif

    // Async reset mid-shift with everything non-zero.
    MSEL = 1'b1; MSO = 1'b1;
    capture(Z);
    shift1(1'b1);
    shift1(1'b0);
    tick();
    pulse_update();
    chk("pre_rst_err", 128'(ERR), 128'(1));
    capture(Z);
    for (int i = 0; i < LEN; i++) shift1(1'b1);
    chk("pre_rst_full", 128'(FULL), 128'(1));
    chk("pre_rst_so", 128'(SO), 128'(1));
    SE = 1'b1;
    #1 RSTB = 1'b0;
    #1;
    chk("rst_mid_q", 128'(Q), 128'(0));
    chk("rst_mid_so", 128'(SO), 128'(0));
    chk("rst_mid_full", 128'(FULL), 128'(0));
    chk("rst_mid_err", 128'(ERR), 128'(0));
    SE = 1'b0; MSEL = 1'b0; MSO = 1'b0;
    #4 RSTB = 1'b1;
    shift1(1'b1);
    chk("rst_idle_shift", 128'(FULL), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
